mem_stage_access_unit: RTL
==========================

// Module: mem_stage_access_unit
// PURPOSE
// MEM-stage data-memory sequencer fed directly by PipelineRegister_EX_MEM outputs.
// - Executes loads/stores of byte, halfword or word over a byte-wide req/ack bus to data memory.
// - Stalls the pipeline while the access runs.
// - Returns sign- or zero-extended load data toward the MEM/WB stage.
// - Byte order is big-endian, matching instruction memory: the byte at addr is the MSB.
// PARAMETERS
// ADDR_W   9    data-memory byte address width (512 B); bus_addr wraps modulo 2^ADDR_W
// TIMEOUT  15   max cycles to wait for bus_ack per byte; 0 disables the timeout
// PORTS
// Clk            in   1       pipeline clock, rising edge
// R              in   1       asynchronous reset, active-low
// MEM_DataMem_enable in 1     memory operation present in MEM stage
// MEM_Read_Write in   1       0=load, 1=store
// MEM_SE_dm      in   1       1=sign-extend load, 0=zero-extend (ignored for word/store)
// MEM_size_dm    in   2       00=byte, 01=halfword, 10=word, 11=illegal
// MEM_Address    in   32      effective byte address (ALU result)
// MEM_DataIn     in   32      store data (rd value)
// MEM_DataOut    out  32      load result, extended
// MEM_Stall      out  1       1 = hold PC, nPC, IF/ID, ID/EX and EX/MEM
// MEM_Done       out  1       one-cycle pulse when the operation completes
// MEM_Misaligned out  1       sticky for the DONE cycle: illegal size or unaligned address
// MEM_BusError   out  1       DONE-cycle flag: ack timeout occurred
// bus_req        out  1       byte transfer request
// bus_we         out  1       1 = write byte
// bus_addr       out  ADDR_W  byte address
// bus_wdata      out  8       write byte
// bus_rdata      in   8       read byte, valid with bus_ack
// bus_ack        in   1       transfer accepted/completed this cycle (may be same cycle as req)
// BEHAVIOUR
// Reset (R=0, async): state=IDLE, idx=0, tmo=0, assembly reg=0.
//   All outputs 0: MEM_DataOut=0, bus_req=0, MEM_Stall=0.
//   bus_req drops immediately, including mid-access; the partial transfer is abandoned.
// Byte count n: 1 (byte), 2 (half), 4 (word).
//   Aligned: half requires Address[0]=0; word requires Address[1:0]=00.
// FSM states: IDLE, ACCESS, DONE.
// IDLE:
//   - If enable=1: MEM_Stall=1 combinationally in this same cycle.
//   - On the clock edge, latch rw, SE, size, Address, DataIn; set idx=0, tmo=0.
//   - Next state: ACCESS if aligned and size!=11, else DONE with MEM_Misaligned=1 (no bus activity).
//   - If enable=0: no stall, no bus activity.
// ACCESS:
//   - MEM_Stall=1, bus_req=1, bus_we=rw, bus_addr=Address[ADDR_W-1:0]+idx (mod 2^ADDR_W).
//   - bus_wdata = byte (n-1-idx) of DataIn counted from LSB.
//     Byte store sends DataIn[7:0]; word store sends [31:24] first.
//   - On bus_ack:
//     - Load: asm <= {asm[23:0], bus_rdata}.
//     - tmo <= 0; idx++.
//     - If idx==n-1, go to DONE.
//   - Without ack: tmo++. If TIMEOUT!=0 and tmo==TIMEOUT-1 → DONE with MEM_BusError=1.
//     MEM_DataOut is unchanged on timeout.
// DONE (exactly 1 cycle):
//   - MEM_Stall=0, MEM_Done=1, bus_req=0; error flags valid; next state IDLE.
//   - The pipeline advances at the end of this cycle, so the new EX/MEM contents are sampled in IDLE.
// MEM_DataOut update: on the ACCESS→DONE edge of a successful load.
//   - byte: SE ? {{24{b7}},b} : {24'b0,b}
//   - half: SE ? {{16{h15}},h} : {16'b0,h}
//   - word: asm
//   - Held until the next successful load; stores and errors leave it unchanged.
// Latency with zero-wait ack: n+2 cycles per op, stall asserted n+1 cycles.
//   - Word load: 6 cycles.
//   - Each ack wait cycle adds 1.
// Back-to-back memory ops: the second op starts in the IDLE cycle after DONE; there is no bubble beyond DONE.
// Input changes during ACCESS are ignored because operands are latched.
// bus_ack arriving in IDLE or DONE is ignored.
// TESTING
// 1 Word load, Address=0x010, mem[0x10..0x13]=DE AD BE EF, ack immediate
//   -> 4 reqs at addr 0x010-0x013; MEM_DataOut=0xDEADBEEF; MEM_Stall high 5 cycles; MEM_Done pulses once.
// 2 Byte load, Address=0x021, mem=0x80: SE=1 -> 0xFFFFFF80; SE=0 -> 0x00000080.
//   Halfword 0x8001 with SE=1 -> 0xFFFF8001.
// 3 Halfword store, DataIn=0x12345678, Address=0x040
//   -> writes 0x56 @0x040 then 0x78 @0x041 with bus_we=1; MEM_DataOut unchanged.
// 4 Word load at Address=0x002, and size=11 at any address
//   -> no bus_req; stall 1 cycle; MEM_Misaligned=1 with MEM_Done.
// 5 Byte load, ack withheld, TIMEOUT=15
//   -> bus_req held 15 cycles, then DONE with MEM_BusError=1; a later ack is ignored.
// 6 R driven low mid-ACCESS of a word load (after 2 acks)
//   -> bus_req and MEM_Stall drop immediately, MEM_DataOut=0.
//   After release, a new op runs normally from IDLE.
//   Also run the wrap case: Address=0x1FF byte store hits bus_addr 0x1FF.

Source files
------------

// File: rtl/mem_stage_access_unit.sv
// MEM-stage data-memory sequencer: runs byte/half/word loads and stores
// over a byte-wide req/ack bus (big-endian) and stalls the pipeline meanwhile.
//
// Ports:
//   Clk, R                  clock (rising edge), async active-low reset
//   MEM_DataMem_enable      memory op present in MEM stage
//   MEM_Read_Write          0 = load, 1 = store
//   MEM_SE_dm, MEM_size_dm  sign-extend select, size (00 b, 01 h, 10 w)
//   MEM_Address, MEM_DataIn effective address, store data
//   MEM_DataOut             extended load result, held between loads
//   MEM_Stall, MEM_Done     pipeline hold, completion pulse
//   MEM_Misaligned          DONE-cycle flag: illegal size / unaligned
//   MEM_BusError            DONE-cycle flag: ack timeout
//   bus_*                   byte-wide request/acknowledge bus
module mem_stage_access_unit #(
    parameter int ADDR_W  = 9,
    parameter int TIMEOUT = 15
) (
    input  logic              Clk,
    input  logic              R,
    input  logic              MEM_DataMem_enable,
    input  logic              MEM_Read_Write,
    input  logic              MEM_SE_dm,
    input  logic [1:0]        MEM_size_dm,
    input  logic [31:0]       MEM_Address,
    input  logic [31:0]       MEM_DataIn,
    output logic [31:0]       MEM_DataOut,
    output logic              MEM_Stall,
    output logic              MEM_Done,
    output logic              MEM_Misaligned,
    output logic              MEM_BusError,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [7:0]        bus_wdata,
    input  logic [7:0]        bus_rdata,
    input  logic              bus_ack
);

    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic              rw_q, rw_d;
    logic              se_q, se_d;
    logic [1:0]        size_q, size_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       din_q, din_d;
    logic [1:0]        idx_q, idx_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic [31:0]       asm_q, asm_d;
    logic [31:0]       dout_q, dout_d;
    logic              mis_q, mis_d;
    logic              berr_q, berr_d;

    logic              req_ok;
    logic [1:0]        last_q;
    logic [1:0]        wsel;
    logic [31:0]       asm_next;
    logic              unused_addr;

    assign unused_addr = ^MEM_Address[31:ADDR_W];

    function automatic logic [1:0] last_idx(input logic [1:0] sz);
        case (sz)
            2'b00:   return 2'd0;
            2'b01:   return 2'd1;
            default: return 2'd3;
        endcase
    endfunction

    function automatic logic [31:0] extend(input logic [1:0]  sz,
                                           input logic        se,
                                           input logic [31:0] a);
        case (sz)
            2'b00:   return {{24{se & a[7]}}, a[7:0]};
            2'b01:   return {{16{se & a[15]}}, a[15:0]};
            default: return a;
        endcase
    endfunction

    always_comb begin
        req_ok = 1'b0;
        unique case (1'b1)
            (MEM_size_dm == 2'b00): req_ok = 1'b1;
            (MEM_size_dm == 2'b01): req_ok = ~MEM_Address[0];
            (MEM_size_dm == 2'b10): req_ok = (MEM_Address[1:0] == 2'b00);
            default:                req_ok = 1'b0;
        endcase
    end

    assign last_q   = last_idx(size_q);
    // Big-endian: the first byte on the bus is the most significant one.
    assign wsel     = last_q - idx_q;
    assign asm_next = {asm_q[23:0], bus_rdata};
    assign bus_addr = addr_q + ADDR_W'(idx_q);

    always_comb begin
        bus_wdata = din_q[7:0];
        unique case (wsel)
            2'd0: bus_wdata = din_q[7:0];
            2'd1: bus_wdata = din_q[15:8];
            2'd2: bus_wdata = din_q[23:16];
            2'd3: bus_wdata = din_q[31:24];
            default: bus_wdata = din_q[7:0];
        endcase
    end

    always_comb begin
        state_d   = state_q;
        rw_d      = rw_q;
        se_d      = se_q;
        size_d    = size_q;
        addr_d    = addr_q;
        din_d     = din_q;
        idx_d     = idx_q;
        tmo_d     = tmo_q;
        asm_d     = asm_q;
        dout_d    = dout_q;
        mis_d     = mis_q;
        berr_d    = berr_q;
        MEM_Stall = 1'b0;
        MEM_Done  = 1'b0;
        bus_req   = 1'b0;
        bus_we    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (MEM_DataMem_enable) begin
                    // Gated by R so the stall is low while reset is held.
                    MEM_Stall = R;
                    rw_d      = MEM_Read_Write;
                    se_d      = MEM_SE_dm;
                    size_d    = MEM_size_dm;
                    addr_d    = MEM_Address[ADDR_W-1:0];
                    din_d     = MEM_DataIn;
                    idx_d     = 2'd0;
                    tmo_d     = '0;
                    asm_d     = '0;
                    mis_d     = ~req_ok;
                    berr_d    = 1'b0;
                    state_d   = req_ok ? ACCESS : DONE;
                end
            end
            ACCESS: begin
                MEM_Stall = 1'b1;
                bus_req   = 1'b1;
                bus_we    = rw_q;
                if (bus_ack) begin
                    tmo_d = '0;
                    idx_d = idx_q + 2'd1;
                    if (!rw_q) asm_d = asm_next;
                    if (idx_q == last_q) begin
                        state_d = DONE;
                        if (!rw_q) dout_d = extend(size_q, se_q, asm_next);
                    end
                end else begin
                    tmo_d = tmo_q + 1'b1;
                    if (TIMEOUT != 0 && tmo_q == TW'(TIMEOUT - 1)) begin
                        berr_d  = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                MEM_Done = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign MEM_Misaligned = MEM_Done & mis_q;
    assign MEM_BusError   = MEM_Done & berr_q;
    assign MEM_DataOut    = dout_q;

    always_ff @(posedge Clk or negedge R) begin
        if (!R) begin
            state_q <= IDLE;
            rw_q    <= 1'b0;
            se_q    <= 1'b0;
            size_q  <= 2'b00;
            addr_q  <= '0;
            din_q   <= '0;
            idx_q   <= 2'd0;
            tmo_q   <= '0;
            asm_q   <= '0;
            dout_q  <= '0;
            mis_q   <= 1'b0;
            berr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rw_q    <= rw_d;
            se_q    <= se_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            idx_q   <= idx_d;
            tmo_q   <= tmo_d;
            asm_q   <= asm_d;
            dout_q  <= dout_d;
            mis_q   <= mis_d;
            berr_q  <= berr_d;
        end
    end

endmodule
